// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Interlock scheduler for a 5-stage MIPS pipeline. Each cycle it decides
// whether the instruction sitting in ID may advance. On a load-use,
// branch/JR operand, or HI/LO (mul/div busy) hazard it holds the PC and
// IF/ID register and loads a bubble into ID/EXE. It also keeps a small
// record of the destinations in flight in EXE and MEM, sequences the
// multi-cycle mul/div unit through a busy counter, and counts hazard
// stall cycles for performance debug.
//
// Build option:
//   HAZARD_MULDIV_EN  defined   -> mul/div busy counter and HI/LO hazard built.
//                     undefined -> no counter, MD_Busy tied low, no HI/LO
//                                  hazard (Hazard_Src never reports 3).
//
// Parameters:
//   MD_LATENCY     cycles the mul/div unit stays busy after a start (1..15)
//
// Ports:
//   CLK            pipeline clock, rising edge
//   RESET          asynchronous reset, active low
//   EXT_Stall      global freeze from memory; whole pipeline holds
//   ID_Valid       ID holds a real instruction
//   ID_rs, ID_rt   source register numbers
//   ID_uses_rs/rt  instruction actually reads that operand
//   ID_branch      branch or JR; operands consumed in ID
//   ID_reg_write   instruction writes a GPR
//   ID_dest        resolved destination GPR
//   ID_load        instruction is a load
//   ID_muldiv      MULT/MULTU/DIV/DIVU
//   ID_reads_hilo  MFHI/MFLO/MTHI/MTLO
//   IF_Stall       hold the PC
//   ID_Stall       hold the IF/ID register
//   EXE_Bubble     load a NOP into ID/EXE this cycle
//   MD_Start       one-cycle start pulse to the mul/div unit
//   MD_Busy        mul/div result not yet available
//   Hazard_Src     stall cause: 0 none, 1 load-use, 2 branch/JR, 3 HI/LO
//   Stall_Count    hazard stall cycles since reset (wraps)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EXT_Stall,
  input  logic        ID_Valid,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_uses_rs,
  input  logic        ID_uses_rt,
  input  logic        ID_branch,
  input  logic        ID_reg_write,
  input  logic [4:0]  ID_dest,
  input  logic        ID_load,
  input  logic        ID_muldiv,
  input  logic        ID_reads_hilo,
  output logic        IF_Stall,
  output logic        ID_Stall,
  output logic        EXE_Bubble,
  output logic        MD_Start,
  output logic        MD_Busy,
  output logic [1:0]  Hazard_Src,
  output logic [31:0] Stall_Count
);

  // In-flight destination record. dest == 0 means "writes nothing", which
  // can never match because register 0 is excluded from matching.
  typedef struct packed {
    logic [4:0] dest;
    logic       load;
  } entry_t;

  entry_t exe_q;
  entry_t mem_q;

  // ---------------------------------------------------------------------------
  // Operand matching against the EXE and MEM entries
  // ---------------------------------------------------------------------------
  logic rs_exe, rt_exe, rs_mem, rt_mem;
  logic exe_hit, mem_hit;

  assign rs_exe  = ID_uses_rs && (ID_rs != 5'd0) && (ID_rs == exe_q.dest);
  assign rt_exe  = ID_uses_rt && (ID_rt != 5'd0) && (ID_rt == exe_q.dest);
  assign rs_mem  = ID_uses_rs && (ID_rs != 5'd0) && (ID_rs == mem_q.dest);
  assign rt_mem  = ID_uses_rt && (ID_rt != 5'd0) && (ID_rt == mem_q.dest);
  assign exe_hit = rs_exe || rt_exe;
  assign mem_hit = rs_mem || rt_mem;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic branch_haz, load_haz, hilo_haz, hazard;

  // A branch reads its operands in ID, so it cannot use the EXE forward of
  // an ALU result, and a load in MEM has not produced its data yet either.
  assign branch_haz = ID_Valid && ID_branch &&
                      (exe_hit || (mem_hit && mem_q.load));

  // Ordinary consumers get every result forwarded except a load still in EXE.
  assign load_haz   = ID_Valid && exe_hit && exe_q.load;

`ifdef HAZARD_MULDIV_EN
  // Both HI/LO accesses and a second mul/div must wait for the unit to drain.
  assign hilo_haz   = ID_Valid && MD_Busy && (ID_reads_hilo || ID_muldiv);
`else
  assign hilo_haz   = 1'b0;
`endif

  assign hazard = branch_haz || load_haz || hilo_haz;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    Hazard_Src = 2'd0;
    if (branch_haz) begin
      Hazard_Src = 2'd2;
    end else if (load_haz) begin
      Hazard_Src = 2'd1;
    end else if (hilo_haz) begin
      Hazard_Src = 2'd3;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control outputs
  // ---------------------------------------------------------------------------
  assign ID_Stall   = hazard || EXT_Stall;
  assign IF_Stall   = hazard || EXT_Stall;
  // A global freeze holds ID/EXE as-is; injecting a NOP would drop the
  // instruction already sitting there.
  assign EXE_Bubble = hazard && !EXT_Stall;
  assign MD_Start   = ID_Valid && ID_muldiv && !hazard && !EXT_Stall;

  // ---------------------------------------------------------------------------
  // In-flight destination tracking
  // ---------------------------------------------------------------------------
  // NOTE: the entries are cleared by reset because a stale destination left
  // over from before reset would raise phantom stalls on the first
  // instructions fetched afterwards.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values; mem_q <= exe_q relies on that.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      exe_q <= '0;
      mem_q <= '0;
    end else if (!EXT_Stall) begin
      mem_q <= exe_q;
      if (ID_Valid && ID_reg_write && !hazard) begin
        exe_q <= {ID_dest, ID_load};
      end else begin
        exe_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mul/div busy counter
  // ---------------------------------------------------------------------------
`ifdef HAZARD_MULDIV_EN
  logic [3:0] cnt;

  // The unit keeps computing through a memory freeze, so the counter does
  // not look at EXT_Stall.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= 4'd0;
    end else if (MD_Start) begin
      cnt <= 4'(MD_LATENCY);
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign MD_Busy = (cnt != 4'd0);
`else
  assign MD_Busy = 1'b0;

  logic unused_md;
  assign unused_md = ^{ID_reads_hilo, 32'(MD_LATENCY)};
`endif

  // ---------------------------------------------------------------------------
  // Stall statistics: counts hazard cycles, including those that coincide
  // with a global freeze. Wraps naturally at 32 bits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Stall_Count <= 32'd0;
    end else if (hazard) begin
      Stall_Count <= Stall_Count + 32'd1;
    end
  end

endmodule
